// File: rtl/match_ctl.sv
// match_ctl: PONG match sequencer (serve/rally/point/pause/over),
// miss detection from ball x, score keeping and winner declaration.
// Ports: clk, rst (sync, active-low), start_btn (debounced level),
//   ball_xpos[10:0] -> ball_rst, score_l/score_r[3:0], point_pulse,
//   game_over, winner (0=left,1=right), match_state[2:0].
// Option: define MATCH_WIN_BY_TWO_EN to require a two-point margin.
module match_ctl #(
  parameter int HOR_LIMIT        = 1024,
  parameter int WIN_SCORE        = 5,
  parameter int PAUSE_CYCLES     = 65_000_000,
  parameter int SERVE_RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic [10:0] ball_xpos,
  output logic        ball_rst,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        point_pulse,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  match_state
);

  localparam int SW = (SERVE_RST_CYCLES > 1) ?
                      $clog2(SERVE_RST_CYCLES) : 1;
  localparam int PW = (PAUSE_CYCLES > 1) ?
                      $clog2(PAUSE_CYCLES) : 1;

  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_RST_CYCLES - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_CYCLES - 1);
  localparam logic [10:0]   HLIM       = 11'(HOR_LIMIT);
  localparam logic [4:0]    WIN        = 5'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          start_q;
  logic          start_rise;
  logic          side_q;
  logic          miss_r;
  logic          miss_l;
  logic [SW-1:0] srv_cnt;
  logic [PW-1:0] pau_cnt;
  logic [3:0]    own_old;
  logic [3:0]    own_new;
  logic          win;
  logic          win_side;

  assign start_rise = start_btn & ~start_q;

  // miss_r: left side missed, right scores; zero takes priority
  assign miss_r = (ball_xpos == 11'd0);
  assign miss_l = ~miss_r & (ball_xpos >= HLIM);

  // side_q = 1 means the right player took the point
  assign own_old = side_q ? score_r : score_l;
  assign own_new = (own_old == 4'd15) ? 4'd15 : own_old + 4'd1;

`ifdef MATCH_WIN_BY_TWO_EN
  logic [3:0] opp_old;

  assign opp_old = side_q ? score_l : score_r;

  // A side parked at 15 cannot build a margin: the next point
  // settles the match for the leader, and 15:15 goes to the scorer.
  always_comb begin
    win      = 1'b0;
    win_side = side_q;
    if (({1'b0, own_new} >= WIN) &&
        ({1'b0, own_new} >= {1'b0, opp_old} + 5'd2)) begin
      win = 1'b1;
    end else if (own_old == 4'd15) begin
      win = 1'b1;
    end else if ((opp_old == 4'd15) && (own_new != 4'd15)) begin
      win      = 1'b1;
      win_side = ~side_q;
    end
  end
`else
  assign win      = ({1'b0, own_new} >= WIN);
  assign win_side = side_q;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start_rise) nxt = SERVE;
      SERVE: if (srv_cnt == SERVE_LAST) nxt = RALLY;
      RALLY: if (miss_r | miss_l) nxt = POINT;
      POINT: nxt = win ? OVER : PAUSE;
      PAUSE: if (pau_cnt == PAUSE_LAST) nxt = SERVE;
      OVER:  if (start_rise) nxt = SERVE;
      default: nxt = IDLE;
    endcase
  end

  assign ball_rst    = (state != RALLY);
  assign point_pulse = (state == POINT);
  assign game_over   = (state == OVER);
  assign match_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      side_q  <= 1'b0;
      srv_cnt <= '0;
      pau_cnt <= '0;
      score_l <= 4'd0;
      score_r <= 4'd0;
      winner  <= 1'b0;
    end else begin
      state   <= nxt;
      start_q <= start_btn;
      // counters restart from zero whenever their state is entered
      if ((state == SERVE) && (nxt == SERVE)) begin
        srv_cnt <= srv_cnt + SW'(1);
      end else begin
        srv_cnt <= '0;
      end
      if ((state == PAUSE) && (nxt == PAUSE)) begin
        pau_cnt <= pau_cnt + PW'(1);
      end else begin
        pau_cnt <= '0;
      end
      if ((state == RALLY) && (nxt == POINT)) begin
        side_q <= miss_r;
      end
      if (state == POINT) begin
        if (side_q) begin
          score_r <= own_new;
        end else begin
          score_l <= own_new;
        end
        if (win) begin
          winner <= win_side;
        end
      end
      if (start_rise && ((state == IDLE) || (state == OVER))) begin
        score_l <= 4'd0;
        score_r <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_match_ctl.sv
// tb_match_ctl: randomized match play against a point-level
// reference model of the scoring and phase timing rules.
module tb_match_ctl;

  localparam int W = 3;
  localparam int P = 20;
  localparam int S = 4;
  localparam int H = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b0;
  logic [10:0] ball_xpos = 11'd500;
  logic        ball_rst;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        point_pulse;
  logic        game_over;
  logic        winner;
  logic [2:0]  match_state;

  int n_vec = 0;
  int n_err = 0;
  int sl = 0;
  int sr = 0;

  always #5 clk = ~clk;

  match_ctl #(
    .HOR_LIMIT(H),
    .WIN_SCORE(W),
    .PAUSE_CYCLES(P),
    .SERVE_RST_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_btn(start_btn),
    .ball_xpos(ball_xpos),
    .ball_rst(ball_rst),
    .score_l(score_l),
    .score_r(score_r),
    .point_pulse(point_pulse),
    .game_over(game_over),
    .winner(winner),
    .match_state(match_state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_scores(input string tag);
    chk({tag, "_l"}, int'(score_l), sl);
    chk({tag, "_r"}, int'(score_r), sr);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_st"}, int'(match_state), 0);
    chk({tag, "_brst"}, int'(ball_rst), 1);
    chk({tag, "_go"}, int'(game_over), 0);
    chk_scores(tag);
  endtask

  // Spec-level scoring rule: returns match end and winning side
  task automatic judge(input bit rs, input int old_me, input int old_opp,
                       output bit done, output bit ws);
    int me;
    me   = (old_me + 1 > 15) ? 15 : old_me + 1;
    done = 1'b0;
    ws   = rs;
`ifdef MATCH_WIN_BY_TWO_EN
    if (me >= W && me - old_opp >= 2) begin
      done = 1'b1;
    end else if (old_me == 15) begin
      done = 1'b1;
    end else if (old_opp == 15 && me < 15) begin
      done = 1'b1;
      ws   = ~rs;
    end
`else
    done = (me >= W);
`endif
  endtask

  task automatic press();
    start_btn = 1'b0;
    cyc();
    start_btn = 1'b1;
    sl = 0;
    sr = 0;
  endtask

  // button left high throughout: a held button must not re-serve
  task automatic serve_then_rally();
    for (int i = 0; i < S; i++) begin
      cyc();
      chk("serve_st", int'(match_state), 1);
      chk("serve_brst", int'(ball_rst), 1);
      if (i == 0) begin
        chk_scores("serve_sc");
        chk("serve_go", int'(game_over), 0);
      end
    end
    cyc();
    chk("rally_st0", int'(match_state), 2);
    chk("rally_brst", int'(ball_rst), 0);
  endtask

  // code: 0 = play continues, 1 = match over, 2 = reset mid-pause
  task automatic play_point(input bit rs, input int abort_at,
                            output int code);
    int  n;
    bit  done;
    bit  ws;
    n = $urandom_range(0, 6);
    ball_xpos = 11'd1023;
    for (int i = 0; i <= n; i++) begin
      cyc();
      chk("rally_st", int'(match_state), 2);
      chk("no_pulse", int'(point_pulse), 0);
      if ($urandom_range(0, 1) == 1) start_btn = ~start_btn;
      ball_xpos = 11'($urandom_range(1, H - 1));
    end
    ball_xpos = rs ? 11'd0 : 11'($urandom_range(H, 2047));
    cyc();
    chk("point_st", int'(match_state), 3);
    chk("point_pulse", int'(point_pulse), 1);
    chk_scores("point_old");
    ball_xpos = 11'd500;
    if (rs) begin
      judge(rs, sr, sl, done, ws);
      sr = (sr + 1 > 15) ? 15 : sr + 1;
    end else begin
      judge(rs, sl, sr, done, ws);
      sl = (sl + 1 > 15) ? 15 : sl + 1;
    end
    cyc();
    chk_scores("point_new");
    chk("pulse_off", int'(point_pulse), 0);
    chk("post_brst", int'(ball_rst), 1);
    chk("post_st", int'(match_state), done ? 5 : 4);
    chk("post_go", int'(game_over), done ? 1 : 0);
    if (done) begin
      chk("winner", int'(winner), int'(ws));
      code = 1;
      return;
    end
    for (int i = 1; i < P; i++) begin
      if (i == abort_at) begin
        rst = 1'b0;
        cyc();
        sl = 0;
        sr = 0;
        chk_idle("abort");
        rst = 1'b1;
        code = 2;
        return;
      end
      if ($urandom_range(0, 3) == 0) start_btn = ~start_btn;
      cyc();
      chk("pause_st", int'(match_state), 4);
      chk("pause_brst", int'(ball_rst), 1);
    end
    serve_then_rally();
    code = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int code;
    int k;
    rst = 1'b0;
    repeat (3) cyc();
    chk_idle("reset");
    chk("reset_pulse", int'(point_pulse), 0);
    chk("reset_win", int'(winner), 0);
    rst = 1'b1;
    repeat (8) begin
      cyc();
      chk_idle("idle");
    end

    // 1:2 then reset partway through the pause
    press();
    serve_then_rally();
    play_point(1'b0, -1, code);
    play_point(1'b1, -1, code);
    play_point(1'b1, 7, code);
    repeat (4) begin
      cyc();
      chk_idle("post_abort");
    end

    for (int m = 0; m < 6; m++) begin
      press();
      serve_then_rally();
      code = 0;
      k = 0;
      while (code == 0 && k < 64) begin
        play_point(1'($urandom_range(0, 1)), -1, code);
        k++;
      end
      if (code != 1) chk("match_end", int'(game_over), 1);
      repeat ($urandom_range(2, 6)) begin
        cyc();
        chk("over_st", int'(match_state), 5);
        chk("over_brst", int'(ball_rst), 1);
        chk_scores("over_hold");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/match_ctl.md
Name: match_ctl

Overview:
Match sequencer for the PONG datapath: sequences the ball controller through serve, rally and point phases; detects misses from ball x-position; keeps both scores; declares the winner.
- Sits between the debounced player start button, the ball controller (drives its reset) and the score/text overlay.
- The ball controller is treated as a resource that is re-armed by a reset pulse for every serve.

Parameters:
- HOR_LIMIT, 1024, ball x-position at or above which the left player has scored (right side missed).
- WIN_SCORE, 5, points needed to win the match (1..15).
- PAUSE_CYCLES, 65_000_000, post-point pause length in clk cycles before the next serve.
- SERVE_RST_CYCLES, 4, length in cycles of the ball reset pulse at each serve.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- start_btn  in  1  debounced start/restart button, level.
- ball_xpos  in  11  ball x-position from the ball controller.
- ball_rst  out  1  active-high reset to the ball controller.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- point_pulse  out  1  one-cycle strobe when a point is awarded.
- game_over  out  1  high while the match is finished.
- winner  out  1  0 = left, 1 = right; valid only while game_over = 1.
- match_state  out  3  current state encoding, for the overlay and debug.

Behaviour:
- Registers and reset:
  - All registers update on posedge clk.
  - rst = 0 at a clock edge forces: state IDLE, score_l = score_r = 0, ball_rst = 1, point_pulse = 0, game_over = 0, winner = 0, all counters 0, start-edge register 0.
  - Reset asserted in any state, including mid-pause, aborts immediately to these values.
- start_btn handling:
  - Rising edge detected with one register: start_rise = start_btn & ~start_q.
  - Only rising edges act; holding the button does nothing further.
- State encoding: IDLE = 0, SERVE = 1, RALLY = 2, POINT = 3, PAUSE = 4, OVER = 5. Unused codes go to IDLE on the next cycle.
- IDLE:
  - ball_rst = 1.
  - On start_rise: clear both scores, clear the serve counter, go to SERVE.
- SERVE:
  - ball_rst = 1 for exactly SERVE_RST_CYCLES cycles, counted by the serve counter.
  - When the counter reaches SERVE_RST_CYCLES-1, go to RALLY next cycle. ball_rst = 0 from the first RALLY cycle.
- RALLY:
  - ball_rst = 0.
  - ball_xpos == 0: right player scores, go to POINT.
  - ball_xpos >= HOR_LIMIT: left player scores, go to POINT.
  - Both conditions cannot hold together. Equality with 0 takes priority if the encoding ever allows it.
  - start_btn is ignored.
- POINT (exactly one cycle):
  - Increment the scoring side's score and assert point_pulse = 1 for this cycle.
  - Scores saturate at 15 (no wrap).
  - Win check uses the incremented value. If the new score >= WIN_SCORE (subject to the optional feature), go to OVER and set winner. Otherwise go to PAUSE.
  - Whether a point went left or right is latched on leaving RALLY.
- PAUSE:
  - ball_rst = 1, which freezes the ball at centre.
  - Pause counter counts from 0 to PAUSE_CYCLES-1, then goes to SERVE; the serve counter is cleared on entry to SERVE.
  - start_btn is ignored.
- OVER:
  - game_over = 1 and ball_rst = 1. Scores and winner hold.
  - On start_rise: clear scores, game_over = 0, go to SERVE.
- Counter widths: ceil(log2) of their parameter. Neither counter ever wraps; each is cleared on state entry.
- Latencies:
  - Miss condition to point_pulse: 1 cycle.
  - Miss condition to score update visible: 2 cycles.
  - start_rise to first ball_rst-low cycle: SERVE_RST_CYCLES + 1 cycles.

Optional Feature:
- Macro: MATCH_WIN_BY_TWO_EN.
- Defined: a side wins only if its new score >= WIN_SCORE and exceeds the opponent's score by at least 2. Otherwise play continues through PAUSE.
  - If either score would reach 15 without a win, that score saturates and the match ends on the next point with winner = the leader.
  - At 15:15, the next point wins.
- Undefined: win on the first side to reach WIN_SCORE; no margin logic synthesised.

Test Plan (all scenarios use WIN_SCORE = 3, PAUSE_CYCLES = 20, SERVE_RST_CYCLES = 4, HOR_LIMIT = 1024):
- Reset/idle: hold rst = 0 for 3 cycles, release, no button -> ball_rst = 1, scores 0/0, match_state = 0, game_over = 0 indefinitely.
- Serve timing: start_btn 0->1 -> ball_rst high exactly 4 cycles in SERVE, low on cycle 5 (match_state = 2). Holding start_btn high causes no second serve.
- Left miss: in RALLY drive ball_xpos = 0 -> point_pulse one cycle later, score_r = 1, score_l = 0. Then 20 PAUSE cycles with ball_rst = 1, then a new 4-cycle serve.
- Right miss: drive ball_xpos = 1030 -> score_l increments by 1. Values 1023 and 500 award no point.
- Match end: three right-side misses -> score_l = 3, game_over = 1, winner = 0, ball_rst = 1. start_btn edge -> scores 0/0, SERVE.
- Reset mid-pause: assert rst = 0 during PAUSE at score 1:2 -> next cycle IDLE, scores 0/0, ball_rst = 1. With MATCH_WIN_BY_TWO_EN, 3:2 continues and 4:2 ends with winner = 0.
